// File: rtl/seg_scan_ctrl.sv
// Four-digit BCD up/down counter with a prescaled step rate, driving a
// time-multiplexed digit scanner with optional blanking between digits.
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 12000000,
    parameter int SCAN_DIV  = 10000,
    parameter int BLANK_CYC = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        dir,
    input  logic        step,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic [3:0]  digit_bcd,
    output logic [3:0]  digit_sel,
    output logic        blank,
    output logic        wrap
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } scan_state_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   count_q, count_d;
    logic          wrap_q, wrap_d;
    logic [3:0]    digit_q;
    logic          adv;
    logic [15:0]   count_step;
    logic          carry_out;

    scan_state_e   state_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    k_q;
    logic [3:0]    digit_sel_q;
    logic          blank_q;

    // Returns {carry_out, next_value}; carry_out marks a 9999->0000 or 0000->9999 wrap.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[4*i +: 4];
            if (c) begin
                if (up) begin
                    if (d >= 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [3:0] one_hot(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    // A manual step only counts while paused; while running, only the prescaler advances.
    assign adv = run ? (presc_q == PRESC_LAST) : step;
    assign {carry_out, count_step} = bcd_step(count_q, dir);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        presc_d = presc_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            presc_d = '0;
            count_d = 16'h0000;
        end else begin
            if (!run || presc_q == PRESC_LAST) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
            if (adv) begin
                count_d = count_step;
                wrap_d  = carry_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            count_q <= 16'h0000;
            wrap_q  <= 1'b0;
            digit_q <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            presc_q <= presc_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            digit_q <= count_q[{k_q, 2'b00} +: 4];
        end
    end

    // Scan FSM; outputs are registered alongside the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SHOW;
            timer_q     <= '0;
            k_q         <= 2'd0;
            digit_sel_q <= 4'b0001;
            blank_q     <= 1'b0;
        end else begin
            case (state_q)
                S_SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        timer_q <= '0;
                        if (BLANK_CYC == 0) begin
                            k_q         <= k_q + 2'd1;
                            digit_sel_q <= one_hot(k_q + 2'd1);
                            blank_q     <= 1'b0;
                        end else begin
                            state_q     <= S_BLANK;
                            digit_sel_q <= 4'b0000;
                            blank_q     <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end
                S_BLANK: begin
                    if (timer_q == BLANK_LAST) begin
                        timer_q     <= '0;
                        state_q     <= S_SHOW;
                        k_q         <= k_q + 2'd1;
                        digit_sel_q <= one_hot(k_q + 2'd1);
                        blank_q     <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end
                default: begin
                    state_q     <= S_SHOW;
                    timer_q     <= '0;
                    digit_sel_q <= one_hot(k_q);
                    blank_q     <= 1'b0;
                end
            endcase
        end
    end

    assign count_bcd = count_q;
    assign digit_bcd = digit_q;
    assign digit_sel = digit_sel_q;
    assign blank     = blank_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with TICK_DIV=4, SCAN_DIV=3, BLANK_CYC=1.
module tb_seg_scan_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int SCAN_DIV  = 3;
    localparam int BLANK_CYC = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, dir, step, clr;
    logic [15:0] count_bcd;
    logic [3:0]  digit_bcd, digit_sel;
    logic        blank, wrap;

    int checks = 0;
    int errors = 0;
    int sc = 0;          // rising edges since the last reset release
    int model_cnt = 0;   // expected count as a plain integer
    logic [15:0] exp_q[$];

    seg_scan_ctrl #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .dir      (dir),
        .step     (step),
        .clr      (clr),
        .count_bcd(count_bcd),
        .digit_bcd(digit_bcd),
        .digit_sel(digit_sel),
        .blank    (blank),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] to_bcd(input int v);
        int x;
        x = v % 10000;
        return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic logic [3:0] exp_sel(input int s);
        int p;
        p = s % 16;
        if (p % 4 == 3) return 4'b0000;
        return 4'b0001 << (p / 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        sc++;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        model_cnt = (model_cnt + (dir ? 1 : 9999)) % 10000;
    endtask

    task automatic step_to(input int target);
        dir = 1'b1;
        for (int i = 0; i < 10000 && model_cnt != target; i++) begin
            pulse_step();
            tick();
        end
    endtask

    task automatic do_reset();
        clr   = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sc = 0;
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        run = 1'b0; dir = 1'b1; step = 1'b0; clr = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", count_bcd); end
        checks++; if (digit_bcd !== 4'h0) begin errors++; $display("FAIL reset_digit_bcd: got %h expected 0", digit_bcd); end
        checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL reset_digit_sel: got %b expected 0001", digit_sel); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b expected 0", blank); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
        tick();
        tick();
        checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL reset_hold_sel: got %b expected 0001", digit_sel); end
        rst_n = 1'b1;
        sc = 0;
    endtask

    task automatic test_count_up();
        logic [15:0] prev, exp;
        int last_chg;
        run = 1'b1; dir = 1'b1;
        do_reset();
        prev = 16'h0000;
        last_chg = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n % 4 == 0) exp_q.push_back(to_bcd(n / 4));
            tick();
            if (count_bcd !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL count_up_unexpected: change to %h at cycle %0d", count_bcd, n);
                end else begin
                    exp = exp_q.pop_front();
                    if (count_bcd !== exp) begin errors++; $display("FAIL count_up_value: got %h expected %h at cycle %0d", count_bcd, exp, n); end
                end
                checks++; if (n - last_chg != TICK_DIV) begin errors++; $display("FAIL count_up_interval: got %0d expected %0d", n - last_chg, TICK_DIV); end
                checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL count_up_wrap: got %b expected 0", wrap); end
                last_chg = n;
                prev = count_bcd;
            end
        end
        checks++; if (count_bcd !== 16'h0010) begin errors++; $display("FAIL count_up_at_40: got %h expected 0010", count_bcd); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL count_up_missing: got %0d pending expected 0", exp_q.size()); end
        exp_q.delete();
        run = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] exp;
        run = 1'b0;
        do_reset();
        dir = 1'b0;
        exp_q.push_back(to_bcd((model_cnt + 9999) % 10000));
        pulse_step();
        exp = exp_q.pop_front();
        checks++; if (count_bcd !== exp) begin errors++; $display("FAIL wrap_down_value: got %h expected %h", count_bcd, exp); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_down_pulse: got %b expected 1", wrap); end
        tick();
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_down_len: got %b expected 0", wrap); end
        checks++; if (count_bcd !== 16'h9999) begin errors++; $display("FAIL wrap_hold: got %h expected 9999", count_bcd); end
        dir = 1'b1;
        exp_q.push_back(to_bcd((model_cnt + 1) % 10000));
        pulse_step();
        exp = exp_q.pop_front();
        checks++; if (count_bcd !== exp) begin errors++; $display("FAIL wrap_up_value: got %h expected %h", count_bcd, exp); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_up_pulse: got %b expected 1", wrap); end
        tick();
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_up_len: got %b expected 0", wrap); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        run = 1'b0;
        do_reset();
        dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(to_bcd(model_cnt + 1));
            pulse_step();
            exp = exp_q.pop_front();
            checks++; if (count_bcd !== exp) begin errors++; $display("FAIL step_paused: got %h expected %h", count_bcd, exp); end
        end
        // Running now: the step pulse on edge 2 must be ignored, and the prescaler starts from 0.
        run = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            if (n == 2) step = 1'b1;
            if (n == 4) exp_q.push_back(to_bcd(model_cnt + 1));
            tick();
            step = 1'b0;
            if (n < 4) begin
                checks++; if (count_bcd !== to_bcd(model_cnt)) begin errors++; $display("FAIL step_running_ignored: got %h expected %h at %0d", count_bcd, to_bcd(model_cnt), n); end
            end else begin
                model_cnt++;
                exp = exp_q.pop_front();
                checks++; if (count_bcd !== exp) begin errors++; $display("FAIL step_run_resume: got %h expected %h", count_bcd, exp); end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_clr();
        logic [15:0] exp;
        run = 1'b0;
        do_reset();
        step_to(42);
        checks++; if (count_bcd !== 16'h0042) begin errors++; $display("FAIL clr_preload: got %h expected 0042", count_bcd); end
        run = 1'b1; dir = 1'b1;
        tick(); tick(); tick();
        checks++; if (count_bcd !== 16'h0042) begin errors++; $display("FAIL clr_before: got %h expected 0042", count_bcd); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_cnt = 0;
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL clr_value: got %h expected 0000", count_bcd); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL clr_wrap: got %b expected 0", wrap); end
        for (int n = 1; n <= 4; n++) begin
            if (n == 4) exp_q.push_back(to_bcd(1));
            tick();
            if (n < 4) begin
                checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL clr_prescaler: got %h expected 0000 at %0d", count_bcd, n); end
            end else begin
                model_cnt = 1;
                exp = exp_q.pop_front();
                checks++; if (count_bcd !== exp) begin errors++; $display("FAIL clr_next_step: got %h expected %h", count_bcd, exp); end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_dir_change();
        logic [15:0] exp;
        run = 1'b0;
        do_reset();
        step_to(100);
        run = 1'b1; dir = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            if (n == 3) dir = 1'b0;
            if (n == 6) dir = 1'b1;
            if (n == 4) exp_q.push_back(to_bcd(99));
            if (n == 8) exp_q.push_back(to_bcd(100));
            tick();
            if (n == 4 || n == 8) begin
                model_cnt = (n == 4) ? 99 : 100;
                exp = exp_q.pop_front();
                checks++; if (count_bcd !== exp) begin errors++; $display("FAIL dir_change_value: got %h expected %h at %0d", count_bcd, exp, n); end
            end else begin
                checks++; if (count_bcd !== to_bcd(model_cnt)) begin errors++; $display("FAIL dir_change_hold: got %h expected %h at %0d", count_bcd, to_bcd(model_cnt), n); end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_scan();
        int pc, pk;
        logic [15:0] pb;
        logic [3:0] exp_d;
        logic stepped;
        run = 1'b0;
        do_reset();
        step_to(1234);
        dir = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pc = model_cnt;
            pk = (sc % 16) / 4;
            stepped = (i % 2 == 0);
            step = stepped;
            tick();
            step = 1'b0;
            if (stepped) model_cnt = (model_cnt + 1) % 10000;
            pb = to_bcd(pc);
            exp_d = pb[pk*4 +: 4];
            checks++; if (digit_sel !== exp_sel(sc)) begin errors++; $display("FAIL scan_sel: got %b expected %b at phase %0d", digit_sel, exp_sel(sc), sc % 16); end
            checks++; if (blank !== (sc % 4 == 3)) begin errors++; $display("FAIL scan_blank: got %b expected %b at phase %0d", blank, (sc % 4 == 3), sc % 16); end
            checks++; if (digit_bcd !== exp_d) begin errors++; $display("FAIL scan_digit: got %h expected %h at phase %0d", digit_bcd, exp_d, sc % 16); end
        end
        checks++; if (count_bcd !== to_bcd(model_cnt)) begin errors++; $display("FAIL scan_count: got %h expected %h", count_bcd, to_bcd(model_cnt)); end
    endtask

    task automatic test_async_reset();
        run = 1'b0;
        do_reset();
        step_to(123);
        for (int i = 0; i < 16 && sc % 16 != 11; i++) tick();
        checks++; if (count_bcd !== 16'h0123) begin errors++; $display("FAIL areset_pre_count: got %h expected 0123", count_bcd); end
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL areset_pre_blank: got %b expected 1", blank); end
        checks++; if (digit_sel !== 4'b0000) begin errors++; $display("FAIL areset_pre_sel: got %b expected 0000", digit_sel); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count_bcd !== 16'h0000) begin errors++; $display("FAIL areset_count: got %h expected 0000", count_bcd); end
        checks++; if (digit_bcd !== 4'h0) begin errors++; $display("FAIL areset_digit_bcd: got %h expected 0", digit_bcd); end
        checks++; if (digit_sel !== 4'b0001) begin errors++; $display("FAIL areset_sel: got %b expected 0001", digit_sel); end
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL areset_blank: got %b expected 0", blank); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap: got %b expected 0", wrap); end
        tick();
        rst_n = 1'b1;
        sc = 0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_back_to_back();
        test_clr();
        test_dir_change();
        test_scan();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
